// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C slave datapath.
package i2c_slave_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DATA  = 2'd2,
    ACK   = 2'd3
  } tx_state_t;

  localparam logic SDA_RELEASE = 1'b1;

endpackage

// File: rtl/i2c_scl_edge_detect.sv
// SCL edge detector; scl_last starts high so a bus that idles high yields no spurious edge.
module i2c_scl_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  output logic rise,
  output logic fall
);

  logic scl_last_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_last_reg <= 1'b1;
    end else begin
      scl_last_reg <= scl_i;
    end
  end

  assign fall = scl_last_reg & ~scl_i;
  assign rise = ~scl_last_reg & scl_i;

endmodule

// File: rtl/i2c_slave_byte_tx_ctrl.sv
// Slave byte transmitter: shifts one byte MSB-first onto SDA during SCL low, then samples ACK.
// Optional ACK sampling is enabled with the I2C_SLAVE_TX_ACK_SAMPLE_EN macro.
module i2c_slave_byte_tx_ctrl
  import i2c_slave_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_write_en,
  input  logic [DATA_W-1:0] byte_write_i,
  input  logic              abort_i,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_o,
  output logic              busy,
  output logic              byte_write_finish,
  output logic              ack_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  tx_state_t         state_reg, state_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic              sda_reg, sda_next;
  logic              finish_reg, finish_next;
  logic              rise, fall;

`ifdef I2C_SLAVE_TX_ACK_SAMPLE_EN
  logic ack_q_reg, ack_q_next;
  logic ack_reg, ack_next;
`else
  logic ack_sample_unused;
  assign ack_sample_unused = sda_i ^ rise;
`endif

  i2c_scl_edge_detect u_scl_edge (
    .clk   (clk),
    .rst   (rst),
    .scl_i (scl_i),
    .rise  (rise),
    .fall  (fall)
  );

  always_comb begin
    state_next   = state_reg;
    data_next    = data_reg;
    bit_cnt_next = bit_cnt_reg;
    sda_next     = sda_reg;
    finish_next  = 1'b0;
`ifdef I2C_SLAVE_TX_ACK_SAMPLE_EN
    ack_q_next   = ack_q_reg;
    ack_next     = ack_reg;
`endif

    unique case (state_reg)
      IDLE: begin
        if (byte_write_en) begin
          state_next   = SETUP;
          data_next    = byte_write_i;
          bit_cnt_next = CNT_W'(DATA_W - 1);
        end
      end
      // A fall seen on SETUP exit is deliberately not treated as a bit boundary.
      SETUP: begin
        if (!scl_i) begin
          state_next = DATA;
          sda_next   = data_reg[DATA_W-1];
        end
      end
      DATA: begin
        if (fall) begin
          if (bit_cnt_reg != '0) begin
            data_next    = data_reg << 1;
            sda_next     = data_reg[DATA_W-2];
            bit_cnt_next = bit_cnt_reg - 1'b1;
          end else begin
            sda_next   = SDA_RELEASE;
            state_next = ACK;
          end
        end
      end
      ACK: begin
`ifdef I2C_SLAVE_TX_ACK_SAMPLE_EN
        if (rise) begin
          ack_q_next = ~sda_i;
        end
`endif
        if (fall) begin
          finish_next = 1'b1;
          state_next  = IDLE;
`ifdef I2C_SLAVE_TX_ACK_SAMPLE_EN
          ack_next    = ack_q_reg;
`endif
        end
      end
      default: state_next = IDLE;
    endcase

    // Bus START/STOP overrides everything, including a same-cycle ACK sample.
    if (abort_i) begin
      state_next  = IDLE;
      sda_next    = SDA_RELEASE;
      finish_next = 1'b0;
`ifdef I2C_SLAVE_TX_ACK_SAMPLE_EN
      ack_q_next  = ack_q_reg;
      ack_next    = ack_reg;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      data_reg    <= '0;
      bit_cnt_reg <= '0;
      sda_reg     <= SDA_RELEASE;
      finish_reg  <= 1'b0;
`ifdef I2C_SLAVE_TX_ACK_SAMPLE_EN
      ack_q_reg   <= 1'b0;
      ack_reg     <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      data_reg    <= data_next;
      bit_cnt_reg <= bit_cnt_next;
      sda_reg     <= sda_next;
      finish_reg  <= finish_next;
`ifdef I2C_SLAVE_TX_ACK_SAMPLE_EN
      ack_q_reg   <= ack_q_next;
      ack_reg     <= ack_next;
`endif
    end
  end

  assign sda_o             = sda_reg;
  assign busy              = (state_reg != IDLE);
  assign byte_write_finish = finish_reg;
`ifdef I2C_SLAVE_TX_ACK_SAMPLE_EN
  assign ack_o             = ack_reg;
`else
  assign ack_o             = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_slave_byte_tx_ctrl.sv
// Directed bench for i2c_slave_byte_tx_ctrl: frames, SETUP hold, ignored request, abort, reset in ACK.
module tb_i2c_slave_byte_tx_ctrl;

`ifdef I2C_SLAVE_TX_ACK_SAMPLE_EN
  localparam logic ACK_EN = 1'b1;
`else
  localparam logic ACK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       byte_write_en;
  logic [7:0] byte_write_i;
  logic       abort_i;
  logic       scl_i;
  logic       sda_i;
  logic       sda_o;
  logic       busy;
  logic       byte_write_finish;
  logic       ack_o;

  int total = 0;
  int bad   = 0;
  int fin_cnt = 0;
  int hi_viol = 0;
  logic scl_prev = 1'b1;
  logic sda_prev = 1'b1;
  logic rst_prev = 1'b1;
  logic abort_prev = 1'b0;

  i2c_slave_byte_tx_ctrl #(.DATA_W(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .byte_write_en     (byte_write_en),
    .byte_write_i      (byte_write_i),
    .abort_i           (abort_i),
    .scl_i             (scl_i),
    .sda_i             (sda_i),
    .sda_o             (sda_o),
    .busy              (busy),
    .byte_write_finish (byte_write_finish),
    .ack_o             (ack_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (byte_write_finish) fin_cnt++;
    // sda_o must not move at an edge where SCL was high, unless reset/abort forced it
    if (scl_prev && !rst_prev && !abort_prev && (sda_o !== sda_prev)) hi_viol++;
    scl_prev   <= scl_i;
    sda_prev   <= sda_o;
    rst_prev   <= rst;
    abort_prev <= abort_i;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic scl_pulse(input logic sv, output logic b);
    scl_i = 1'b0;
    sda_i = sv;
    repeat (4) @(negedge clk);
    scl_i = 1'b1;
    repeat (2) @(negedge clk);
    b = sda_o;
    repeat (2) @(negedge clk);
  endtask

  task automatic request(input logic [7:0] d);
    byte_write_en = 1'b1;
    byte_write_i  = d;
    @(negedge clk);
    byte_write_en = 1'b0;
  endtask

  // nine SCL pulses, then the closing fall; checks bits, finish pulse and ack_o
  task automatic frame_body(input logic [7:0] d, input logic sda_ack, input string tag);
    logic [8:0] bits;
    logic       b;
    int         f0;
    f0   = fin_cnt;
    bits = '0;
    for (int i = 0; i < 9; i++) begin
      scl_pulse((i == 8) ? sda_ack : 1'b1, b);
      bits = {bits[7:0], b};
    end
    check({tag, "_bits"}, 32'(bits), 32'({d, 1'b1}));
    scl_i = 1'b0;
    sda_i = 1'b1;
    @(negedge clk);
    check({tag, "_fin_hi"}, 32'(byte_write_finish), 32'd1);
    check({tag, "_busy_lo"}, 32'(busy), 32'd0);
    check({tag, "_ack"}, 32'(ack_o), 32'(ACK_EN & ~sda_ack));
    @(negedge clk);
    check({tag, "_fin_lo"}, 32'(byte_write_finish), 32'd0);
    check({tag, "_fin_cnt"}, 32'(fin_cnt - f0), 32'd1);
    $display("tx %s data=%02h bits=%03h ack_o=%0b", tag, d, bits, ack_o);
  endtask

  task automatic run_frame(input logic [7:0] d, input logic sda_ack, input string tag);
    request(d);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    frame_body(d, sda_ack, tag);
  endtask

  initial begin
    logic [2:0] part;
    logic [5:0] rest;
    logic       b;
    int         f0;

    rst = 1'b1; byte_write_en = 1'b0; byte_write_i = '0;
    abort_i = 1'b0; scl_i = 1'b1; sda_i = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sda", 32'(sda_o), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fin", 32'(byte_write_finish), 32'd0);
    check("rst_ack", 32'(ack_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // request together with abort in IDLE is dropped
    byte_write_en = 1'b1; abort_i = 1'b1; byte_write_i = 8'h55;
    @(negedge clk);
    byte_write_en = 1'b0; abort_i = 1'b0;
    check("abort_req_busy", 32'(busy), 32'd0);
    $display("tx abort_with_request busy=%0b", busy);

    run_frame(8'hA5, 1'b0, "a5_ack");
    run_frame(8'hFF, 1'b1, "ff_nack");

    // SETUP holds while SCL is high; a second request mid-transfer is ignored
    scl_i = 1'b1;
    repeat (2) @(negedge clk);
    request(8'h5A);
    check("setup_busy", 32'(busy), 32'd1);
    check("setup_sda", 32'(sda_o), 32'd1);
    repeat (3) @(negedge clk);
    check("setup_hold_sda", 32'(sda_o), 32'd1);
    check("setup_hold_busy", 32'(busy), 32'd1);
    scl_i = 1'b0;
    @(negedge clk);
    check("setup_msb", 32'(sda_o), 32'd0);
    request(8'h00);
    frame_body(8'h5A, 1'b0, "5a_ignore2nd");

    // abort after the third bit of 0x3C
    f0 = fin_cnt;
    request(8'h3C);
    part = '0;
    for (int i = 0; i < 3; i++) begin
      scl_pulse(1'b1, b);
      part = {part[1:0], b};
    end
    check("abort_first3", 32'(part), 32'b001);
    scl_i = 1'b0;
    repeat (2) @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("abort_sda", 32'(sda_o), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    rest = '0;
    for (int i = 0; i < 6; i++) begin
      scl_pulse(1'b0, b);
      rest = {rest[4:0], b};
    end
    scl_i = 1'b0;
    sda_i = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_released", 32'(rest), 32'h3F);
    check("abort_no_fin", 32'(fin_cnt - f0), 32'd0);
    check("abort_ack_kept", 32'(ack_o), 32'(ACK_EN));
    $display("tx 3c aborted bits=%03b busy=%0b", part, busy);

    run_frame(8'h81, 1'b0, "81_ack");

    // reset while in the ACK slot
    f0 = fin_cnt;
    request(8'hC3);
    for (int i = 0; i < 9; i++) scl_pulse((i == 8) ? 1'b0 : 1'b1, b);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstack_sda", 32'(sda_o), 32'd1);
    check("rstack_busy", 32'(busy), 32'd0);
    check("rstack_fin", 32'(byte_write_finish), 32'd0);
    check("rstack_ack", 32'(ack_o), 32'd0);
    scl_i = 1'b0;
    sda_i = 1'b1;
    repeat (3) @(negedge clk);
    check("rstack_no_fin", 32'(fin_cnt - f0), 32'd0);
    check("rstack_idle", 32'(busy), 32'd0);
    $display("tx c3 reset_in_ack busy=%0b sda_o=%0b", busy, sda_o);

    check("sda_stable_scl_high", 32'(hi_viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
